// File: rtl/eq_pkg.sv
// Shared definitions for the EQ coefficient sequencer.
//   - eq_state_e : sequencer FSM states
//   - ADDR_*     : shadow bank write addresses
//   - COEF_W     : coefficient width (Q3.29)
//   - sat_inc8   : saturating 8-bit increment for the frame counter
package eq_pkg;

  localparam int COEF_W = 32;

  localparam logic [1:0] ADDR_A1 = 2'd0;
  localparam logic [1:0] ADDR_A2 = 2'd1;
  localparam logic [1:0] ADDR_B1 = 2'd2;
  localparam logic [1:0] ADDR_B2 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_UNMUTE = 3'd5
  } eq_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/eq_coef_bank.sv
// Shadow/active coefficient register pair.
//   clk_i, rst_i          : clock, async active-high reset (all regs -> 0)
//   wr_en_i/addr/data     : host write into the shadow bank, any time
//   load_i                : copy all four shadow regs into the active regs
//   a1_o, a2_o, b1_o, b2_o: active coefficients
// A write and a load in the same cycle copy the pre-write shadow value,
// which falls out of both registers updating on the same edge.
module eq_coef_bank
  import eq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [1:0]        wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
  input  logic              load_i,
  output logic [COEF_W-1:0] a1_o,
  output logic [COEF_W-1:0] a2_o,
  output logic [COEF_W-1:0] b1_o,
  output logic [COEF_W-1:0] b2_o
);

  logic [COEF_W-1:0] sh_a1_q, sh_a2_q, sh_b1_q, sh_b2_q;
  logic [COEF_W-1:0] act_a1_q, act_a2_q, act_b1_q, act_b2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sh_a1_q <= '0;
      sh_a2_q <= '0;
      sh_b1_q <= '0;
      sh_b2_q <= '0;
    end else if (wr_en_i) begin
      case (wr_addr_i)
        ADDR_A1: sh_a1_q <= wr_data_i;
        ADDR_A2: sh_a2_q <= wr_data_i;
        ADDR_B1: sh_b1_q <= wr_data_i;
        default: sh_b2_q <= wr_data_i;
      endcase
    end
  end

  // All-zero active bank is a passthrough filter (b0=1 is implicit in the core).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_a1_q <= '0;
      act_a2_q <= '0;
      act_b1_q <= '0;
      act_b2_q <= '0;
    end else if (load_i) begin
      act_a1_q <= sh_a1_q;
      act_a2_q <= sh_a2_q;
      act_b1_q <= sh_b1_q;
      act_b2_q <= sh_b2_q;
    end
  end

  assign a1_o = act_a1_q;
  assign a2_o = act_a2_q;
  assign b1_o = act_b1_q;
  assign b2_o = act_b2_q;

endmodule

// File: rtl/eq_coef_sequencer.sv
// Glitch-free EQ coefficient swap sequencer.
// Mutes the EQ core on a frame boundary, waits FLUSH_FRAMES frames for the
// filter state to drain, swaps all four coefficients at once, waits
// SETTLE_FRAMES frames, then re-enables audio.
//   clk, reset        : clock, async active-high reset
//   process_start     : one-cycle frame strobe shared with the EQ core
//   wr_en/addr/data   : host writes into the shadow bank
//   commit            : request to apply the shadow bank
//   mute_req          : host mute, overrides audio_on
//   a1/a2/b1/b2_out   : active coefficients
//   audio_on          : registered audio enable
//   busy              : high outside IDLE
//   done              : one-cycle pulse in UNMUTE (UNMUTE->IDLE)
module eq_coef_sequencer
  import eq_pkg::*;
#(
  parameter int FLUSH_FRAMES  = 8,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        process_start,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        commit,
  input  logic        mute_req,
  output logic [31:0] a1_out,
  output logic [31:0] a2_out,
  output logic [31:0] b1_out,
  output logic [31:0] b2_out,
  output logic        audio_on,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] FLUSH_N  = 8'(FLUSH_FRAMES);
  localparam logic [7:0] SETTLE_N = 8'(SETTLE_FRAMES);

  eq_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       audio_q, audio_d;
  logic       load;
  logic [7:0] cnt_inc;

  assign cnt_inc = sat_inc8(cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      audio_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      audio_q <= audio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit || pend_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        // Strobes here only start the mute; they are not counted.
        if (process_start) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (process_start) begin
          cnt_d = cnt_inc;
          if (cnt_inc == FLUSH_N) state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (process_start) begin
          cnt_d = cnt_inc;
          if (cnt_inc == SETTLE_N) state_d = ST_UNMUTE;
        end
      end
      ST_UNMUTE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One pending slot: any commit outside IDLE (including the UNMUTE cycle)
  // queues exactly one more sequence. Leaving IDLE always consumes it.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_IDLE) pend_d = 1'b0;
    else if (commit)        pend_d = 1'b1;
  end

  // Audio is only enabled in IDLE, UNMUTE, and ARM until the frame strobe
  // that starts the mute; host mute overrides everything.
  always_comb begin
    audio_d = 1'b0;
    if (!mute_req) begin
      case (state_q)
        ST_IDLE, ST_UNMUTE: audio_d = 1'b1;
        ST_ARM:             audio_d = !process_start;
        default:            audio_d = 1'b0;
      endcase
    end
  end

  eq_coef_bank u_bank (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .load_i    (load),
    .a1_o      (a1_out),
    .a2_o      (a2_out),
    .b1_o      (b1_out),
    .b2_o      (b2_out)
  );

  assign audio_on = audio_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_UNMUTE);

endmodule
